branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_seq_pkg.sv | 33 +++
 rtl/ras_stack.sv | 54 +++++
 rtl/branch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_branch_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_seq_pkg.sv
// Shared types for the branch sequencer: branch-type encodings, FSM states
// and the branch-condition helper used by the top level.
package branch_seq_pkg;

    typedef enum logic [1:0] {
        BR_UNC0 = 2'b00,   // unconditional
        BR_UNC1 = 2'b01,   // unconditional
        BR_C    = 2'b10,   // taken if carry = 1
        BR_NC   = 2'b11    // taken if carry = 0
    } br_type_e;

    typedef enum logic [1:0] {
        BOOT      = 2'b00,
        RUN       = 2'b01,
        WAIT_FLAG = 2'b10,
        FLUSH     = 2'b11
    } seq_state_e;

    // Conditional branches are the only ones that must wait for a final carry.
    function automatic logic br_is_cond(input br_type_e t);
        return (t == BR_C) || (t == BR_NC);
    endfunction

    // Resolve a branch given the (forwarded) carry value.
    function automatic logic br_is_taken(input br_type_e t, input logic c);
        case (t)
            BR_C:    return c;
            BR_NC:   return !c;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack, circular: a push when full overwrites the oldest
// entry, a pop when empty leaves the stack unchanged.
// Ports: clk, rst (async, active-high), push_i/pop_i strobes, wdata_i push
// value, rdata_o top-of-stack value, full_o, empty_o.
module ras_stack #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  top_q;   // next write slot
    logic [CNT_W-1:0]  cnt_q;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[top_q - PTR_W'(1)];

    // Storage has no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[top_q] <= wdata_i;
        end
    end

    // Pointer wraps naturally (DEPTH is a power of two), so a full push
    // lands on the oldest entry while the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            top_q <= top_q + PTR_W'(1);
            if (!full_o) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            top_q <= top_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch-PC sequencer: linear advance, branch resolution with carry
// forwarding, wait for a pending flag write, one-cycle wrong-path flush.
// Every redirect (taken branch, call, return) pulses taken and flushes.
// Optional return stack enabled by macro BRANCH_SEQ_RAS_EN.
// Ports: clk, rst (async, active-high), stall, br_req/br_type/br_target,
// carry_wr/carry_in, flag_pending, call_req/ret_req in; pc, pc_valid,
// flush, taken, ras_err out (all registered).
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_req,
    input  logic [1:0]        br_type,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              carry_wr,
    input  logic              carry_in,
    input  logic              flag_pending,
    input  logic              call_req,
    input  logic              ret_req,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic              taken,
    output logic              ras_err
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_valid_q;
    logic              flush_q;
    logic              taken_q;
    logic              carry_q;
    br_type_e          wtype_q;
    logic [ADDR_W-1:0] wtgt_q;

    logic              carry_fwd;
    logic [ADDR_W-1:0] pc_inc;
    br_type_e          req_type;

    // A carry written this cycle is visible to a branch resolving this cycle.
    assign carry_fwd = carry_wr ? carry_in : carry_q;
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign req_type  = br_type_e'(br_type);

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;
    assign flush    = flush_q;
    assign taken    = taken_q;

`ifdef BRANCH_SEQ_RAS_EN
    logic              ras_err_q;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_rdata;
    logic              ras_full;
    logic              ras_empty;

    // Stack only moves on an accepted request; br_req outranks call/ret.
    assign ras_push = (state_q == RUN) && !stall && !br_req && call_req;
    assign ras_pop  = (state_q == RUN) && !stall && !br_req && !call_req && ret_req;
    assign ras_err  = ras_err_q;

    ras_stack #(
        .DEPTH  (RAS_DEPTH),
        .DATA_W (ADDR_W)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .wdata_i (pc_inc),
        .rdata_o (ras_rdata),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );
`else
    logic ras_unused;
    assign ras_unused = call_req ^ ret_req ^ 1'(RAS_DEPTH % 2);
    assign ras_err    = 1'b0;
`endif

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            taken_q    <= 1'b0;
            carry_q    <= 1'b0;
            wtype_q    <= BR_UNC0;
            wtgt_q     <= '0;
`ifdef BRANCH_SEQ_RAS_EN
            ras_err_q  <= 1'b0;
`endif
        end else begin
            if (carry_wr) begin
                carry_q <= carry_in;
            end
            taken_q <= 1'b0;
`ifdef BRANCH_SEQ_RAS_EN
            ras_err_q <= 1'b0;
`endif
            case (state_q)
                BOOT: begin
                    state_q    <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: if (!stall) begin
                    if (br_req) begin
                        if (br_is_cond(req_type) && flag_pending) begin
                            state_q    <= WAIT_FLAG;
                            pc_valid_q <= 1'b0;
                            wtype_q    <= req_type;
                            wtgt_q     <= br_target;
                        end else if (br_is_taken(req_type, carry_fwd)) begin
                            state_q <= FLUSH;
                            pc_q    <= br_target;
                            flush_q <= 1'b1;
                            taken_q <= 1'b1;
                        end else begin
                            pc_q <= pc_inc;
                        end
                    end
`ifdef BRANCH_SEQ_RAS_EN
                    else if (call_req) begin
                        state_q   <= FLUSH;
                        pc_q      <= br_target;
                        flush_q   <= 1'b1;
                        taken_q   <= 1'b1;
                        ras_err_q <= ras_full;
                    end else if (ret_req) begin
                        state_q   <= FLUSH;
                        pc_q      <= ras_empty ? '0 : ras_rdata;
                        flush_q   <= 1'b1;
                        taken_q   <= 1'b1;
                        ras_err_q <= ras_empty;
                    end
`endif
                    else begin
                        pc_q <= pc_inc;
                    end
                end
                WAIT_FLAG: if (!stall && !flag_pending) begin
                    pc_valid_q <= 1'b1;
                    if (br_is_taken(wtype_q, carry_fwd)) begin
                        state_q <= FLUSH;
                        pc_q    <= wtgt_q;
                        flush_q <= 1'b1;
                        taken_q <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        pc_q    <= pc_inc;
                    end
                end
                FLUSH: if (!stall) begin
                    state_q <= RUN;
                    flush_q <= 1'b0;
                    pc_q    <= pc_inc;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus random
// traffic, all compared against a behavioural model of the sequencer.
module tb_branch_sequencer;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned RAS_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              br_req;
    logic [1:0]        br_type;
    logic [ADDR_W-1:0] br_target;
    logic              carry_wr;
    logic              carry_in;
    logic              flag_pending;
    logic              call_req;
    logic              ret_req;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              flush;
    logic              taken;
    logic              ras_err;

    int n_vec = 0;
    int n_err = 0;

    branch_sequencer #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_req       (br_req),
        .br_type      (br_type),
        .br_target    (br_target),
        .carry_wr     (carry_wr),
        .carry_in     (carry_in),
        .flag_pending (flag_pending),
        .call_req     (call_req),
        .ret_req      (ret_req),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .taken        (taken),
        .ras_err      (ras_err)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_booting;
    bit          m_waiting;
    bit          m_flushing;
    bit          m_valid;
    bit          m_taken;
    bit          m_err;
    bit          m_carry;
    logic [31:0] m_pc;
    logic [1:0]  w_type;
    logic [31:0] w_tgt;
    logic [31:0] m_stack[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit resolves(input logic [1:0] t, input bit c);
        case (t)
            2'b10:   return c;
            2'b11:   return !c;
            default: return 1'b1;
        endcase
    endfunction

    task automatic m_redirect(input logic [31:0] t);
        m_pc       = t;
        m_taken    = 1'b1;
        m_flushing = 1'b1;
    endtask

    task automatic m_resolve(input logic [1:0] t, input logic [31:0] tgt, input bit c);
        if (resolves(t, c)) m_redirect(tgt);
        else m_pc = m_pc + 32'd1;
    endtask

    // One rising edge of the reference behaviour, using the current inputs.
    task automatic model_edge();
        bit c;
        if (rst) begin
            m_booting = 1; m_waiting = 0; m_flushing = 0; m_valid = 0;
            m_taken = 0; m_err = 0; m_carry = 0; m_pc = '0;
            m_stack.delete();
            return;
        end
        c = carry_wr ? carry_in : m_carry;
        m_taken = 0;
        m_err   = 0;
        if (m_booting) begin
            m_booting = 0;
            m_valid   = 1;
        end else if (!stall) begin
            if (m_flushing) begin
                m_flushing = 0;
                m_pc = m_pc + 32'd1;
            end else if (m_waiting) begin
                if (!flag_pending) begin
                    m_waiting = 0;
                    m_valid   = 1;
                    m_resolve(w_type, w_tgt, c);
                end
            end else if (br_req) begin
                if (br_type[1] && flag_pending) begin
                    m_waiting = 1;
                    m_valid   = 0;
                    w_type    = br_type;
                    w_tgt     = br_target;
                end else begin
                    m_resolve(br_type, br_target, c);
                end
            end
`ifdef BRANCH_SEQ_RAS_EN
            else if (call_req) begin
                if (m_stack.size() == RAS_DEPTH) begin
                    void'(m_stack.pop_front());
                    m_err = 1;
                end
                m_stack.push_back(m_pc + 32'd1);
                m_redirect(br_target);
            end else if (ret_req) begin
                if (m_stack.size() == 0) begin
                    m_err = 1;
                    m_redirect(32'd0);
                end else begin
                    m_redirect(m_stack.pop_back());
                end
            end
`endif
            else begin
                m_pc = m_pc + 32'd1;
            end
        end
        if (carry_wr) m_carry = carry_in;
    endtask

    task automatic clear_inputs();
        stall = 0; br_req = 0; br_type = 2'b00; br_target = '0;
        carry_wr = 0; carry_in = 0; flag_pending = 0; call_req = 0; ret_req = 0;
    endtask

    // Advance one clock, update the model, then compare all outputs.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("pc", pc, m_pc);
        chk("pc_valid", pc_valid, m_valid);
        chk("flush", flush, m_flushing);
        chk("taken", taken, m_taken);
        chk("ras_err", ras_err, m_err);
    endtask

    logic [31:0] held_pc;
    logic [31:0] exp_ret[$];

    initial begin
        clear_inputs();
        rst = 1;
        cycle();
        cycle();
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", pc_valid, 1'b0);
        chk("rst_flush", flush, 1'b0);

        // Boot: one invalid cycle at pc 0, then 0,1,2,3 valid
        rst = 0;
        #1;
        chk("boot_pc", pc, 32'd0);
        chk("boot_valid", pc_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("boot_seq_pc", pc, 32'(i));
            chk("boot_seq_valid", pc_valid, 1'b1);
        end

        // Reach pc = 0x10, then a carry-forwarded conditional taken branch
        for (int i = 0; i < 40 && m_pc != 32'h10; i++) cycle();
        chk("at_0x10", pc, 32'h10);
        br_req = 1; br_type = 2'b10; br_target = 32'h1234;
        carry_wr = 1; carry_in = 1;
        cycle();
        chk("bc_pc", pc, 32'h1234);
        chk("bc_taken", taken, 1'b1);
        chk("bc_flush", flush, 1'b1);
        clear_inputs();
        cycle();
        chk("bc_flush_end", flush, 1'b0);
        chk("bc_taken_end", taken, 1'b0);
        chk("bc_next", pc, 32'h1235);

        // Clear carry, then a BR_NC that waits 3 cycles on the flag
        carry_wr = 1; carry_in = 0;
        cycle();
        clear_inputs();
        held_pc = m_pc;
        br_req = 1; br_type = 2'b11; br_target = 32'hABC; flag_pending = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            br_req = 0;
            chk("wait_pc", pc, held_pc);
            chk("wait_valid", pc_valid, 1'b0);
        end
        flag_pending = 0;
        cycle();
        chk("wait_jump", pc, 32'hABC);
        chk("wait_flush", flush, 1'b1);
        clear_inputs();
        cycle();

        // Stall blocks an unconditional request
        held_pc = m_pc;
        stall = 1; br_req = 1; br_type = 2'b00; br_target = 32'h55;
        cycle();
        chk("stall_pc", pc, held_pc);
        chk("stall_taken", taken, 1'b0);
        clear_inputs();
        cycle();
        chk("unstall_pc", pc, held_pc + 32'd1);

        // Wrap from 0xFFFFFFFF to 0
        br_req = 1; br_type = 2'b01; br_target = 32'hFFFF_FFFF;
        cycle();
        clear_inputs();
        chk("wrap_pre", pc, 32'hFFFF_FFFF);
        cycle();
        chk("wrap_pc", pc, 32'd0);

`ifdef BRANCH_SEQ_RAS_EN
        // Five calls then five returns on a depth-4 stack
        exp_ret.delete();
        for (int i = 0; i < 5; i++) begin
            exp_ret.push_back(m_pc + 32'd1);
            call_req = 1; br_target = 32'h100 * 32'(i + 1);
            cycle();
            chk("call_err", ras_err, (i == 4) ? 1'b1 : 1'b0);
            clear_inputs();
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            ret_req = 1;
            cycle();
            if (i < 4) begin
                chk("ret_pc", pc, exp_ret[4 - i]);
                chk("ret_err", ras_err, 1'b0);
            end else begin
                chk("ret_empty_pc", pc, 32'd0);
                chk("ret_empty_err", ras_err, 1'b1);
            end
            clear_inputs();
            cycle();
        end
`else
        held_pc = m_pc;
        call_req = 1; ret_req = 1; br_target = 32'h777;
        cycle();
        chk("noras_pc", pc, held_pc + 32'd1);
        chk("noras_err", ras_err, 1'b0);
        clear_inputs();
        cycle();
`endif

        // Random traffic, including reset mid-wait/mid-flush
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            stall        = ($urandom_range(0, 4) == 0);
            br_req       = ($urandom_range(0, 2) == 0);
            br_type      = 2'($urandom);
            br_target    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom);
            carry_wr     = ($urandom_range(0, 2) == 0);
            carry_in     = 1'($urandom);
            flag_pending = ($urandom_range(0, 2) == 0);
            call_req     = ($urandom_range(0, 5) == 0);
            ret_req      = ($urandom_range(0, 5) == 0);
            cycle();
        end
        clear_inputs();
        rst = 0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
